seq_det_arbiter: RTL and testbench

Shares one serial pattern-detection engine between two requesters. Each requester hands over a parallel word with a req/gnt handshake. The block arbitrates round-robin, serializes the granted word MSB-first through an internal overlapping pattern matcher, and counts matches. It reports completion with the requester ID and the match count. It sits in front of the sequence-detector datapath as its scheduler and sequencer.

---
 rtl/seq_det_arbiter.sv | 158 +++++++++++++++
 tb/tb_seq_det_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seq_det_arbiter.sv
// Round-robin scheduler for a shared serial pattern matcher: grants one of two
// requesters, shifts its word MSB-first through an overlapping matcher, counts hits.
module seq_det_arbiter #(
    parameter int               WORD_W  = 8,
    parameter int               PAT_W   = 5,
    parameter logic [PAT_W-1:0] PATTERN = 5'b10101,
    parameter int               CNT_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [WORD_W-1:0] data0,
    input  logic              req1,
    input  logic [WORD_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              busy,
    output logic              z,
    output logic              done,
    output logic              done_id,
    output logic [CNT_W-1:0]  match_cnt
);

    localparam int BC_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               rr_q, rr_d;
    logic [WORD_W-1:0]  shift_q, shift_d;
    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [PAT_W-1:0]   hist_new;
    logic [BC_W-1:0]    bitcnt_q, bitcnt_d;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic               busy_q, busy_d;
    logic               z_q, z_d;
    logic               done_q, done_d;
    logic               id_q, id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // State and registered outputs; reset also aborts any running job silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rr_q     <= 1'b0;
            shift_q  <= '0;
            hist_q   <= '0;
            bitcnt_q <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            busy_q   <= 1'b0;
            z_q      <= 1'b0;
            done_q   <= 1'b0;
            id_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            shift_q  <= shift_d;
            hist_q   <= hist_d;
            bitcnt_q <= bitcnt_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            busy_q   <= busy_d;
            z_q      <= z_d;
            done_q   <= done_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
        end
    end

    // Arbitration, serialization and match counting.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        shift_d  = shift_q;
        hist_d   = hist_q;
        bitcnt_d = bitcnt_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        z_d      = 1'b0;
        done_d   = 1'b0;
        id_d     = id_q;
        cnt_d    = cnt_q;
        hist_new = {hist_q[PAT_W-2:0], shift_q[WORD_W-1]};

        case (state_q)
            S_IDLE: begin
                // rr_q == 0 means requester 0 wins a tie.
                if (req0 && (!req1 || !rr_q)) begin
                    shift_d  = data0;
                    hist_d   = '0;
                    bitcnt_d = '0;
                    cnt_d    = '0;
                    id_d     = 1'b0;
                    gnt0_d   = 1'b1;
                    rr_d     = 1'b1;
                    state_d  = S_SHIFT;
                end else if (req1) begin
                    shift_d  = data1;
                    hist_d   = '0;
                    bitcnt_d = '0;
                    cnt_d    = '0;
                    id_d     = 1'b1;
                    gnt1_d   = 1'b1;
                    rr_d     = 1'b0;
                    state_d  = S_SHIFT;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_SHIFT: begin
                shift_d  = {shift_q[WORD_W-2:0], 1'b0};
                hist_d   = hist_new;
                bitcnt_d = bitcnt_q + BC_W'(1);
                // bitcnt_q is the count before this bit, so PAT_W-1 means a full pattern is in.
                if ((bitcnt_q >= BC_W'(PAT_W - 1)) && (hist_new == PATTERN)) begin
                    z_d = 1'b1;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else begin
                    z_d = 1'b0;
                end
                if (bitcnt_q == BC_W'(WORD_W - 1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign busy      = busy_q;
    assign z         = z_q;
    assign done      = done_q;
    assign done_id   = id_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Directed bench for seq_det_arbiter: default instance plus a CNT_W=1 instance on shared inputs.
module tb_seq_det_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [7:0] data0, data1;

    logic       gnt0_a, gnt1_a, busy_a, z_a, done_a, id_a;
    logic [3:0] cnt_a;
    logic       gnt0_b, gnt1_b, busy_b, z_b, done_b, id_b;
    logic [0:0] cnt_b;

    int checks = 0;
    int errors = 0;

    seq_det_arbiter dut_a (
        .clk(clk), .reset(reset),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(gnt0_a), .gnt1(gnt1_a), .busy(busy_a), .z(z_a),
        .done(done_a), .done_id(id_a), .match_cnt(cnt_a)
    );

    seq_det_arbiter #(.CNT_W(1)) dut_b (
        .clk(clk), .reset(reset),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .busy(busy_b), .z(z_b),
        .done(done_b), .done_id(id_b), .match_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        data0 = 8'h00;
        data1 = 8'h00;
        step();
        step();
        check_val("rst_busy", int'(busy_a), 0);
        check_val("rst_done", int'(done_a), 0);
        check_val("rst_cnt",  int'(cnt_a), 0);
        check_val("rst_id",   int'(id_a), 0);
        check_val("rst_gnt",  int'({gnt1_a, gnt0_a}), 0);
        reset = 1'b0;
    endtask

    // zmask bit k-1 is the expected z after shift edge k.
    task automatic do_job(input logic who, input logic [7:0] w, input logic [7:0] zmask,
                          input int exp_cnt);
        if (who) begin
            req1 = 1'b1; data1 = w;
        end else begin
            req0 = 1'b1; data0 = w;
        end
        step();
        check_val("gnt0_e0", int'(gnt0_a), int'(!who));
        check_val("gnt1_e0", int'(gnt1_a), int'(who));
        check_val("busy_e0", int'(busy_a), 1);
        check_val("id_e0",   int'(id_a), int'(who));
        check_val("cnt_e0",  int'(cnt_a), 0);
        req0 = 1'b0;
        req1 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check_val("z_a", int'(z_a), int'(zmask[k-1]));
            check_val("z_b", int'(z_b), int'(zmask[k-1]));
            check_val("gnt_shift", int'({gnt1_a, gnt0_a}), 0);
            check_val("done_early", int'(done_a), 0);
        end
        check_val("busy_e8", int'(busy_a), 1);
        step();
        check_val("done_e9",  int'(done_a), 1);
        check_val("id_e9",    int'(id_a), int'(who));
        check_val("cnt_e9",   int'(cnt_a), exp_cnt);
        check_val("cnt_b_e9", int'(cnt_b), (exp_cnt > 1) ? 1 : exp_cnt);
        check_val("busy_e9",  int'(busy_a), 0);
        step();
        check_val("done_e10", int'(done_a), 0);
        check_val("cnt_hold", int'(cnt_a), exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int seen;

        do_reset();
        do_job(1'b0, 8'b10101010, 8'b0101_0000, 2);
        do_job(1'b1, 8'b11111111, 8'b0000_0000, 0);
        do_job(1'b0, 8'b00001010, 8'b0000_0000, 0);
        do_job(1'b1, 8'b10000000, 8'b0000_0000, 0);

        // Simultaneous requests right after reset.
        do_reset();
        req0 = 1'b1; data0 = 8'h11;
        req1 = 1'b1; data1 = 8'h22;
        step();
        check_val("both_gnt0", int'(gnt0_a), 1);
        check_val("both_gnt1", int'(gnt1_a), 0);
        req0 = 1'b0;
        n = 0;
        while (n < 20 && !gnt1_a) begin
            step();
            n++;
        end
        check_val("gnt1_spacing", n, 10);
        check_val("gnt1_id", int'(id_a), 1);
        req1 = 1'b0;
        for (int i = 0; i < 9; i++) step();
        req0 = 1'b1;
        req1 = 1'b1;
        step();
        check_val("rr_gnt0", int'(gnt0_a), 1);
        check_val("rr_gnt1", int'(gnt1_a), 0);
        req0 = 1'b0;
        req1 = 1'b0;
        for (int i = 0; i < 10; i++) step();

        // Reset mid-job on requester 1.
        req1 = 1'b1; data1 = 8'b10101010;
        step();
        check_val("abort_gnt1", int'(gnt1_a), 1);
        req1 = 1'b0;
        step(); step(); step();
        check_val("abort_busy_pre", int'(busy_a), 1);
        reset = 1'b1;
        #1;
        check_val("abort_busy", int'(busy_a), 0);
        check_val("abort_id",   int'(id_a), 0);
        check_val("abort_cnt",  int'(cnt_a), 0);
        check_val("abort_done", int'(done_a), 0);
        step();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done_a || gnt0_a || gnt1_a) seen++;
        end
        check_val("abort_quiet", seen, 0);
        do_job(1'b1, 8'b10101010, 8'b0101_0000, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
